// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-output bundle for seq_pattern_tx.
// master = pattern requester, slave = transmitter.
interface seq_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             x;
  logic             valid;
  logic             ready;
  logic             busy;
  logic             done;
  logic [2:0]       S;

  modport master (
    output start, pattern, len, abort,
    input  x, valid, ready, busy, done, S
  );

  modport slave (
    input  start, pattern, len, abort,
    output x, valid, ready, busy, done, S
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first on x.
// Define SEQ_PATTERN_TX_PARITY_EN to append one even-parity bit per transfer.
module seq_pattern_tx #(
  parameter int WIDTH      = 8,
  parameter int LEN_W      = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  seq_pattern_tx_if.slave  bus
);

  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);

`ifdef SEQ_PATTERN_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    SHIFT  = 3'b001,
    PARITY = 3'b010,
    DONE   = 3'b100
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    SHIFT = 3'b001,
    DONE  = 3'b100
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             x_q, x_d;
  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] first_vec;
  logic [WIDTH-1:0] next_vec;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic             par_q, par_d;
  logic [WIDTH-1:0] len_mask;
`endif

  assign eff_len = (bus.len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.len;

  // Bit selection via right shift keeps the index width independent of WIDTH.
  assign first_vec = bus.pattern >> (eff_len - LEN_W'(1));
  assign next_vec  = shreg_q >> (idx_q - LEN_W'(1));

`ifdef SEQ_PATTERN_TX_PARITY_EN
  assign len_mask = ~({WIDTH{1'b1}} << eff_len);
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      cyc_q   <= '0;
      x_q     <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      x_q     <= x_d;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    x_d     = 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          shreg_d = bus.pattern;
          cyc_d   = '0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
          par_d   = ^(bus.pattern & len_mask);
`endif
          if (eff_len != '0) begin
            state_d = SHIFT;
            idx_d   = eff_len - LEN_W'(1);
            x_d     = first_vec[0];
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
          cyc_d   = '0;
        end else if (cyc_q != CYC_LAST) begin
          cyc_d = cyc_q + CYC_W'(1);
          x_d   = x_q;
        end else begin
          cyc_d = '0;
          if (idx_q != '0) begin
            idx_d = idx_q - LEN_W'(1);
            x_d   = next_vec[0];
          end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
            state_d = PARITY;
            x_d     = par_q;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef SEQ_PATTERN_TX_PARITY_EN
      PARITY: begin
        if (bus.abort) begin
          state_d = IDLE;
          cyc_d   = '0;
        end else if (cyc_q != CYC_LAST) begin
          cyc_d = cyc_q + CYC_W'(1);
          x_d   = x_q;
        end else begin
          cyc_d   = '0;
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.x     = x_q;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  assign bus.valid = (state_q == SHIFT) || (state_q == PARITY);
`else
  assign bus.valid = (state_q == SHIFT);
`endif
  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.S     = state_q;

endmodule
